// File: rtl/fround_pkg.sv
// Shared constants for the round-to-integral unit: rounding mode codes and
// the operand classification carried between pipeline stages.
package fround_pkg;

  localparam logic [1:0] MODE_FLOOR = 2'd0;
  localparam logic [1:0] MODE_CEIL  = 2'd1;
  localparam logic [1:0] MODE_TRUNC = 2'd2;
  localparam logic [1:0] MODE_RNE   = 2'd3;

  typedef enum logic [2:0] {
    CLS_SPECIAL,
    CLS_ZERO,
    CLS_INTEGRAL,
    CLS_SUB_ONE,
    CLS_FRACTIONAL
  } fclass_e;

endpackage

// File: rtl/fround_mask.sv
// Decodes the exponent into the fraction/keep masks, the half-point bit and
// the integer-unit increment (1 << f) used by the rounding stage.
module fround_mask
  import fround_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXP_W-1:0]  exp_i,
  output logic [MANT_W-1:0] keep_mask,
  output logic [MANT_W-1:0] frac_mask,
  output logic [MANT_W-1:0] half_bit,
  output logic [MANT_W:0]   inc_unit
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  logic signed [31:0] f_s;

  // inc_unit is one bit wider so that f = MANT_W lands on the hidden bit.
  always_comb begin
    f_s = 32'(BIAS + MANT_W) - $signed(32'(exp_i));
    for (int i = 0; i < MANT_W; i++) begin
      frac_mask[i] = (f_s > i);
      half_bit[i]  = (f_s == i + 1);
    end
    keep_mask = ~frac_mask;
    for (int i = 0; i <= MANT_W; i++) begin
      inc_unit[i] = (f_s == i);
    end
  end

endmodule

// File: rtl/fround_pipe.sv
// Two-stage round-to-integral unit (floor/ceil/trunc/RNE) with a valid/ready
// handshake; both stages advance together whenever the output can move.
module fround_pipe
  import fround_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_data,
  output logic                    out_inexact
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

  logic                  en;
  logic [MANT_W-1:0]     keep_in, frac_in, half_in;
  logic [MANT_W:0]       inc_in;

  logic                  vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic                  sign_p1_d, sign_p1_q;
  logic [EXP_W-1:0]      exp_p1_d, exp_p1_q;
  logic [MANT_W-1:0]     mant_p1_d, mant_p1_q;
  logic [1:0]            mode_p1_d, mode_p1_q;
  fclass_e               cls_p1_d, cls_p1_q;
  logic [MANT_W-1:0]     keep_p1_d, keep_p1_q, frac_p1_d, frac_p1_q, half_p1_d, half_p1_q;
  logic [MANT_W:0]       inc_p1_d, inc_p1_q;
  logic [EXP_W+MANT_W:0] out_data_d, out_data_q;
  logic                  out_inexact_d, out_inexact_q;

  function automatic fclass_e classify(input logic [EXP_W-1:0] e);
    if (e == '1)                         return CLS_SPECIAL;
    else if (e == '0)                    return CLS_ZERO;
    else if (e < BIAS_E)                 return CLS_SUB_ONE;
    else if (int'(e) >= BIAS + MANT_W)   return CLS_INTEGRAL;
    else                                 return CLS_FRACTIONAL;
  endfunction

  // Returns {inexact, result word}.
  function automatic logic [EXP_W+MANT_W+1:0] round_op(
    input logic              s,
    input logic [EXP_W-1:0]  e,
    input logic [MANT_W-1:0] m,
    input logic [1:0]        mode,
    input fclass_e           cls,
    input logic [MANT_W-1:0] keep,
    input logic [MANT_W-1:0] frac,
    input logic [MANT_W-1:0] half,
    input logic [MANT_W:0]   inc
  );
    logic [MANT_W-1:0] fr, kept;
    logic [MANT_W:0]   sum;
    logic              up, lsb, to_one;
    logic [EXP_W+MANT_W+1:0] res;
    fr     = m & frac;
    kept   = m & keep;
    lsb    = |({1'b1, m} & inc);
    up     = 1'b0;
    to_one = 1'b0;
    sum    = '0;
    res    = {1'b0, s, e, m};
    case (cls)
      CLS_SPECIAL, CLS_INTEGRAL: res = {1'b0, s, e, m};
      CLS_ZERO:                  res = {1'b0, s, {(EXP_W + MANT_W){1'b0}}};
      CLS_SUB_ONE: begin
        case (mode)
          MODE_FLOOR: to_one = s;
          MODE_CEIL:  to_one = !s;
          MODE_TRUNC: to_one = 1'b0;
          default:    to_one = (e == BIAS_E - EXP_W'(1)) && (m != '0);
        endcase
        res = {1'b1, s, (to_one ? BIAS_E : {EXP_W{1'b0}}), {MANT_W{1'b0}}};
      end
      default: begin
        case (mode)
          MODE_FLOOR: up = s && (fr != '0);
          MODE_CEIL:  up = !s && (fr != '0);
          MODE_TRUNC: up = 1'b0;
          default:    up = (fr > half) || ((fr == half) && lsb);
        endcase
        sum = {1'b0, kept} + (up ? inc : {(MANT_W + 1){1'b0}});
        res = {(fr != '0), s, (sum[MANT_W] ? e + EXP_W'(1) : e), sum[MANT_W-1:0]};
      end
    endcase
    return res;
  endfunction

  fround_mask #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_mask (
    .exp_i     (in_data[EXP_W+MANT_W-1:MANT_W]),
    .keep_mask (keep_in),
    .frac_mask (frac_in),
    .half_bit  (half_in),
    .inc_unit  (inc_in)
  );

  always_comb begin
    en       = !vld_p2_q || out_ready;
    in_ready = en;

    // stage 0 -> 1: operand, mode, class and masks
    vld_p1_d  = en ? in_valid : vld_p1_q;
    sign_p1_d = en ? in_data[EXP_W+MANT_W] : sign_p1_q;
    exp_p1_d  = en ? in_data[EXP_W+MANT_W-1:MANT_W] : exp_p1_q;
    mant_p1_d = en ? in_data[MANT_W-1:0] : mant_p1_q;
    mode_p1_d = en ? in_mode : mode_p1_q;
    cls_p1_d  = en ? classify(in_data[EXP_W+MANT_W-1:MANT_W]) : cls_p1_q;
    keep_p1_d = en ? keep_in : keep_p1_q;
    frac_p1_d = en ? frac_in : frac_p1_q;
    half_p1_d = en ? half_in : half_p1_q;
    inc_p1_d  = en ? inc_in : inc_p1_q;

    // stage 1 -> 2: rounded result and inexact flag
    vld_p2_d = en ? vld_p1_q : vld_p2_q;
    {out_inexact_d, out_data_d} = {out_inexact_q, out_data_q};
    if (en && vld_p1_q) begin
      {out_inexact_d, out_data_d} = round_op(sign_p1_q, exp_p1_q, mant_p1_q, mode_p1_q,
                                             cls_p1_q, keep_p1_q, frac_p1_q, half_p1_q,
                                             inc_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    exp_p1_q  <= exp_p1_d;
    mant_p1_q <= mant_p1_d;
    mode_p1_q <= mode_p1_d;
    cls_p1_q  <= cls_p1_d;
    keep_p1_q <= keep_p1_d;
    frac_p1_q <= frac_p1_d;
    half_p1_q <= half_p1_d;
    inc_p1_q  <= inc_p1_d;
  end

  assign out_valid   = vld_p2_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fround_pipe.sv
// Scoreboard bench for fround_pipe at FP32 and FP64, with an integer-arithmetic
// reference model, randomized backpressure and mid-flight reset.
module tb_fround_pipe;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;
  always #5 clk = ~clk;

  logic        in_valid32, in_ready32, out_valid32, out_inexact32;
  logic [1:0]  in_mode32;
  logic [31:0] in_data32, out_data32;
  logic        in_valid64, in_ready64, out_valid64, out_inexact64;
  logic [1:0]  in_mode64;
  logic [63:0] in_data64, out_data64;

  fround_pipe #(.EXP_W(8), .MANT_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_mode(in_mode32), .out_valid(out_valid32),
    .out_ready(out_ready), .out_data(out_data32), .out_inexact(out_inexact32)
  );

  fround_pipe #(.EXP_W(11), .MANT_W(52)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data64), .in_mode(in_mode64), .out_valid(out_valid64),
    .out_ready(out_ready), .out_data(out_data64), .out_inexact(out_inexact64)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;
  logic [32:0] q32[$];
  logic [64:0] q64[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Value-level model: integer quotient of the significand by 2^f, rounded
  // by mode, then re-encoded from the resulting integer.
  function automatic void ref_round(input logic [63:0] w, input int ew, input int mw,
                                    input int mode, output logic [63:0] r, output bit inx);
    longint unsigned sig, q, rem, n, em, m;
    int e, f, bias, p, cmp;
    bit s, nz, up;
    bias = (1 << (ew - 1)) - 1;
    s    = w[ew+mw];
    em   = (64'd1 << ew) - 1;
    e    = int'((w >> mw) & em);
    m    = w & ((64'd1 << mw) - 1);
    inx  = 1'b0;
    r    = w;
    if (e == int'(em)) return;
    if (e == 0) begin
      r = 64'(s) << (ew + mw);
      return;
    end
    f = bias + mw - e;
    if (f <= 0) return;
    sig = (64'd1 << mw) | m;
    if (f <= mw + 1) begin
      q   = sig >> f;
      rem = sig - (q << f);
      nz  = (rem != 0);
      cmp = (2 * rem > (64'd1 << f)) ? 1 : ((2 * rem == (64'd1 << f)) ? 0 : -1);
    end else begin
      q   = 0;
      nz  = 1'b1;
      cmp = -1;
    end
    case (mode)
      0:       up = s && nz;
      1:       up = !s && nz;
      2:       up = 1'b0;
      default: up = (cmp > 0) || (cmp == 0 && q[0]);
    endcase
    n   = q + 64'(up);
    inx = nz;
    r   = 64'(s) << (ew + mw);
    if (n != 0) begin
      p = 0;
      for (int i = 0; i < 64; i++) if (n[i]) p = i;
      r = r | (64'(bias + p) << mw);
      if (p <= mw) r = r | ((n ^ (64'd1 << p)) << (mw - p));
    end
  endfunction

  task automatic issue32(input logic [31:0] w, input logic [1:0] m, input logic [32:0] exp);
    int t = 0;
    in_valid32 = 1'b1; in_data32 = w; in_mode32 = m;
    forever begin
      @(negedge clk);
      if (in_ready32) begin q32.push_back(exp); @(posedge clk); #1; break; end
      @(posedge clk); #1; t++;
      if (t > 200) begin
        n_cmp++; n_err++;
        $display("FAIL issue32_timeout: in_ready=0 for %0d cycles, want 1", t);
        break;
      end
    end
    in_valid32 = 1'b0;
  endtask

  task automatic issue64(input logic [63:0] w, input logic [1:0] m, input logic [64:0] exp);
    int t = 0;
    in_valid64 = 1'b1; in_data64 = w; in_mode64 = m;
    forever begin
      @(negedge clk);
      if (in_ready64) begin q64.push_back(exp); @(posedge clk); #1; break; end
      @(posedge clk); #1; t++;
      if (t > 200) begin
        n_cmp++; n_err++;
        $display("FAIL issue64_timeout: in_ready=0 for %0d cycles, want 1", t);
        break;
      end
    end
    in_valid64 = 1'b0;
  endtask

  task automatic model32(input logic [31:0] w, input logic [1:0] m);
    logic [63:0] r; bit x;
    ref_round({32'b0, w}, 8, 23, int'(m), r, x);
    issue32(w, m, {x, r[31:0]});
  endtask

  task automatic model64(input logic [63:0] w, input logic [1:0] m);
    logic [63:0] r; bit x;
    ref_round(w, 11, 52, int'(m), r, x);
    issue64(w, m, {x, r});
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() != 0 || q64.size() != 0) && t < 200) begin @(posedge clk); t++; end
    #1;
    chk("drain_pending32", 64'(q32.size()), '0);
    chk("drain_pending64", 64'(q64.size()), '0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic [32:0] e;
    logic [31:0] held;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else if (out_valid32 && out_ready) begin
        stalled = 1'b0;
        if (q32.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out32_unexpected: got result %h, want none", out_data32);
        end else begin
          e = q32.pop_front();
          chk("out32_data", 64'(out_data32), 64'(e[31:0]));
          chk("out32_inexact", 64'(out_inexact32), 64'(e[32]));
        end
      end else if (out_valid32) begin
        chk("stall32_in_ready", 64'(in_ready32), '0);
        if (stalled) chk("stall32_hold", 64'(out_data32), 64'(held));
        held = out_data32;
        stalled = 1'b1;
      end else stalled = 1'b0;
    end
  end

  initial begin
    logic [64:0] e;
    logic [63:0] held;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else if (out_valid64 && out_ready) begin
        stalled = 1'b0;
        if (q64.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out64_unexpected: got result %h, want none", out_data64);
        end else begin
          e = q64.pop_front();
          chk("out64_data", out_data64, e[63:0]);
          chk("out64_inexact", 64'(out_inexact64), 64'(e[64]));
        end
      end else if (out_valid64) begin
        if (stalled) chk("stall64_hold", out_data64, held);
        held = out_data64;
        stalled = 1'b1;
      end else stalled = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp[5] = '{32'h40200000, 32'hC0200000, 32'h3FC00000, 32'hBE99999A, 32'h41234567};
    rst = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_mode32 = '0;
    in_valid64 = 1'b0; in_data64 = '0; in_mode64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid32", 64'(out_valid32), '0);
    chk("reset_out_data32", 64'(out_data32), '0);
    chk("reset_out_inexact32", 64'(out_inexact32), '0);
    chk("reset_out_valid64", 64'(out_valid64), '0);
    chk("reset_in_ready32", 64'(in_ready32), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    issue32(32'h40200000, 2'd0, {1'b1, 32'h40000000});
    issue32(32'h40200000, 2'd1, {1'b1, 32'h40400000});
    issue32(32'h40200000, 2'd2, {1'b1, 32'h40000000});
    issue32(32'h40200000, 2'd3, {1'b1, 32'h40000000});
    issue32(32'hC0200000, 2'd0, {1'b1, 32'hC0400000});
    issue32(32'hC0200000, 2'd1, {1'b1, 32'hC0000000});
    issue32(32'hC0200000, 2'd3, {1'b1, 32'hC0000000});
    issue32(32'hBE99999A, 2'd0, {1'b1, 32'hBF800000});
    issue32(32'hBE99999A, 2'd1, {1'b1, 32'h80000000});
    issue32(32'hBFE00000, 2'd0, {1'b1, 32'hC0000000});
    issue32(32'h3FC00000, 2'd3, {1'b1, 32'h40000000});
    issue32(32'h3F000000, 2'd3, {1'b1, 32'h00000000});
    issue32(32'h3F000001, 2'd3, {1'b1, 32'h3F800000});
    issue32(32'h4B000000, 2'd3, {1'b0, 32'h4B000000});
    issue32(32'h7FC00000, 2'd0, {1'b0, 32'h7FC00000});
    issue32(32'h80000001, 2'd1, {1'b0, 32'h80000000});
    issue64(64'hC004000000000000, 2'd0, {1'b1, 64'hC008000000000000});
    issue64(64'h4004000000000000, 2'd3, {1'b1, 64'h4000000000000000});
    issue64(64'h3FF8000000000000, 2'd3, {1'b1, 64'h4000000000000000});
    issue64(64'h4330000000000000, 2'd2, {1'b0, 64'h4330000000000000});
    drain();

    fork
      begin
        for (int i = 0; i < 5; i++) model32(bp[i], 2'(i));
      end
      begin
        repeat (2) @(posedge clk);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain();

    ready_mode = 1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [7:0] ex;
          ex = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(120, 152));
          model32({1'($urandom), ex, 23'($urandom)}, 2'($urandom_range(0, 3)));
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [10:0] ex;
          ex = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(1018, 1078));
          model64({1'($urandom), ex, 20'($urandom), 32'($urandom)}, 2'($urandom_range(0, 3)));
        end
      end
    join
    ready_mode = 0;
    drain();

    issue32(32'h40200000, 2'd1, {1'b1, 32'h40400000});
    issue32(32'hC0200000, 2'd0, {1'b1, 32'hC0400000});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("midreset_out_valid32", 64'(out_valid32), '0);
    chk("midreset_out_data32", 64'(out_data32), '0);
    chk("midreset_in_ready32", 64'(in_ready32), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    issue32(32'hBFE00000, 2'd0, {1'b1, 32'hC0000000});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fround_pipe.md
# fround_pipe

Parametrised, pipelined floating-point round-to-integral unit for the FPU. It generalises the single-mode floor unit to four rounding modes, selectable per operation, and to any IEEE-style binary format. It adds a valid/ready handshake with backpressure and an inexact flag. It sits beside the other FPU arithmetic units and feeds the common result arbiter.

## Interface
- EXP_W, 8, exponent field width
- MANT_W, 23, stored mantissa field width (total word W = 1+EXP_W+MANT_W)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  unit accepts operand this cycle
- in_data  in  W  operand {sign, exp, mant}
- in_mode  in  2  0 floor, 1 ceil, 2 trunc, 3 round-nearest-even (RNE)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  rounded result
- out_inexact  out  1  result differs numerically from operand

## Operation
- BIAS = 2^(EXP_W-1)-1. Let e = exp field, f = fraction-bit count = BIAS+MANT_W-e.
- exp all-ones (Inf/NaN): pass through unchanged; inexact 0.
- e = 0 (zero/subnormal): flushed to ±0 with sign kept; inexact 0.
- f <= 0 (already integral): pass through; inexact 0.
- e < BIAS (|x| < 1, nonzero): result is ±0 or ±1.0, sign kept.
  - floor gives -1.0 if negative, else +0.
  - ceil gives +1.0 if positive, else -0.
  - trunc gives ±0.
  - RNE gives ±1.0 only when e = BIAS-1 and mant ≠ 0 (|x| > 0.5); otherwise ±0.
  - inexact 1.
- 1 <= f <= MANT_W: frac = mant low f bits; kept = mant with low f bits cleared.
  - Increment magnitude at bit f when:
    - floor: sign=1 and frac≠0
    - ceil: sign=0 and frac≠0
    - trunc: never
    - RNE: frac > half, or frac = half and bit f of mant is 1
  - The increment carries out of the mantissa when kept bits are all ones. Result is then {sign, e+1, 0}. e+1 never reaches all-ones, because f >= 1.
  - inexact = (frac ≠ 0).
- Mode is sampled with the operand and travels with it.

## Timing
- Two register stages.
  - Stage 1 registers the operand, mode, class, shift masks and increment unit.
  - Stage 2 registers the final result and inexact flag.
- Latency: an operand accepted in cycle N gives out_valid in cycle N+2 when there is no stall. Throughput is 1 per cycle.
- Advance enable: en = !out_valid | out_ready. in_ready = en (combinational from out_ready). Both stages advance together only when en = 1.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stall: while out_valid=1 and out_ready=0, out_data, out_inexact and stage-1 contents hold stable. in_ready=0 during a stall.
- Bubbles: stage valid bits propagate, so an empty stage-1 cannot create an out_valid.
- Reset, including mid-operation: the next edge clears both valid bits and sets out_data=0 and out_inexact=0. In-flight operands are discarded, and in_ready=1 in the cycle after reset.

## Structure
- Package fround_pkg holds:
  - mode constants MODE_FLOOR=0, MODE_CEIL=1, MODE_TRUNC=2, MODE_RNE=3
  - class encoding: SPECIAL, ZERO, INTEGRAL, SUB_ONE, FRACTIONAL
- One sub-module, fround_mask. It is combinational and parametrised by EXP_W/MANT_W. From the exponent it produces:
  - keep mask
  - fraction mask
  - half-point bit
  - increment unit (1<<f)
- The top holds the two stages and the handshake.

## Test plan
- FP32, mode sweep on 2.5 (0x40200000):
  - floor → 0x40000000
  - ceil → 0x40400000
  - trunc → 0x40000000
  - RNE → 0x40000000
  - inexact=1 in every case
- Negative and small values:
  - -2.5 (0xC0200000): floor → 0xC0400000; ceil and RNE → 0xC0000000
  - -0.3 (0xBE99999A): floor → 0xBF800000; ceil → 0x80000000
- Carry into exponent:
  - -1.75 (0xBFE00000) floor → 0xC0000000
  - 1.5 (0x3FC00000) RNE → 0x40000000
  - 0.5 (0x3F000000) RNE → 0x00000000
- Passthrough:
  - 0x4B000000 (2^23) → unchanged, inexact=0
  - NaN 0x7FC00000 → unchanged
  - subnormal 0x80000001 → 0x80000000
- Backpressure: stream 5 back-to-back operands with out_ready held low for 3 cycles mid-stream. Required: no loss or duplication, in-order results, and out_data stable while stalled.
- Reset and parameter check:
  - Assert rst with 2 operands in flight → out_valid=0 the next cycle, no stale results afterwards.
  - Repeat key cases at EXP_W=11/MANT_W=52: -2.5 (0xC004000000000000) floor → 0xC008000000000000.
